// File: rtl/pc_sequencer.sv
// pc_sequencer: 12-bit program counter with RUN/HALT/FAULT control and
// push/pop/write-data drive for a downstream return-address stack.
// Optional feature macro: STACK_GUARD_EN (call at full / ret at empty -> FAULT).
module pc_sequencer #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic        call,
    input  logic        ret,
    input  logic [11:0] target,
    input  logic [11:0] stack_top,
    output logic [11:0] pc,
    output logic        push,
    output logic        pop,
    output logic [11:0] push_data,
    output logic [3:0]  depth,
    output logic        halted,
    output logic        fault
);

    localparam int unsigned PC_W    = 12;
    localparam int unsigned DEPTH_W = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               push_c, pop_c;
    logic [PC_W-1:0]    pc_inc_c;
    logic               full_c, empty_c;

    assign pc_inc_c = pc_q + PC_W'(1);
    assign full_c   = (depth_q == DEPTH_MAX);
    assign empty_c  = (depth_q == '0);

    // State, PC and depth registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    // Next-state, next-PC and stack strobe selection by request priority
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        if (state_q == ST_RUN && !stall) begin
            if (halt) begin
                state_d = ST_HALT;
            end else if (ret) begin
`ifdef STACK_GUARD_EN
                if (empty_c) begin
                    state_d = ST_FAULT;
                end else begin
                    pop_c   = 1'b1;
                    pc_d    = stack_top;
                    depth_d = depth_q - DEPTH_W'(1);
                end
`else
                pop_c   = 1'b1;
                pc_d    = stack_top;
                depth_d = empty_c ? depth_q : depth_q - DEPTH_W'(1);
`endif
            end else if (call) begin
`ifdef STACK_GUARD_EN
                if (full_c) begin
                    state_d = ST_FAULT;
                end else begin
                    push_c  = 1'b1;
                    pc_d    = target;
                    depth_d = depth_q + DEPTH_W'(1);
                end
`else
                push_c  = 1'b1;
                pc_d    = target;
                depth_d = full_c ? depth_q : depth_q + DEPTH_W'(1);
`endif
            end else if (jump || branch_taken) begin
                pc_d = target;
            end else begin
                pc_d = pc_inc_c;
            end
        end
        // A request coinciding with reset must never reach the stack
        if (rst) begin
            push_c = 1'b0;
            pop_c  = 1'b0;
        end
    end

    assign pc        = pc_q;
    assign depth     = depth_q;
    assign push      = push_c;
    assign pop       = pop_c;
    assign push_data = pc_inc_c;
    assign halted    = (state_q == ST_HALT);
`ifdef STACK_GUARD_EN
    assign fault     = (state_q == ST_FAULT);
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_PC = 12'h010).
// Expectations for stack boundary cases follow STACK_GUARD_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, halt, jump, branch_taken, call, ret;
    logic [11:0] target, stack_top;
    logic [11:0] pc, push_data;
    logic        push, pop, halted, fault;
    logic [3:0]  depth;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer #(.RESET_PC(12'h010), .STACK_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt(halt), .jump(jump),
        .branch_taken(branch_taken), .call(call), .ret(ret),
        .target(target), .stack_top(stack_top), .pc(pc), .push(push),
        .pop(pop), .push_data(push_data), .depth(depth), .halted(halted),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall = 1'b0; halt = 1'b0; jump = 1'b0;
        branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
        target = 12'h000; stack_top = 12'h000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic goto_pc(input logic [11:0] a);
        idle_inputs();
        jump = 1'b1; target = a;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (pc !== 12'h010) begin n_fail++; $display("FAIL reset_pc got %h exp 010", pc); end
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got %0d exp 0", depth); end
        n_cmp++; if (halted !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_flags got h=%b f=%b exp 0 0", halted, fault); end
        for (int i = 1; i <= 3; i++) begin
            n_cmp++; if (push !== 1'b0 || pop !== 1'b0) begin n_fail++; $display("FAIL idle_strobes got push=%b pop=%b exp 0 0", push, pop); end
            tick();
            n_cmp++; if (pc !== 12'(12'h010 + i)) begin n_fail++; $display("FAIL idle_pc%0d got %h exp %h", i, pc, 12'(12'h010 + i)); end
        end
        n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL idle_depth got %0d exp 0", depth); end
    endtask

    task automatic test_call_ret();
        do_reset();
        goto_pc(12'h020);
        call = 1'b1; target = 12'h100;
        #1;
        n_cmp++; if (push !== 1'b1 || pop !== 1'b0) begin n_fail++; $display("FAIL call_strobes got push=%b pop=%b exp 1 0", push, pop); end
        n_cmp++; if (push_data !== 12'h021) begin n_fail++; $display("FAIL call_push_data got %h exp 021", push_data); end
        tick();
        n_cmp++; if (pc !== 12'h100 || depth !== 4'd1) begin n_fail++; $display("FAIL call_next got pc=%h depth=%0d exp 100 1", pc, depth); end
        idle_inputs();
        ret = 1'b1; stack_top = 12'h021;
        #1;
        n_cmp++; if (pop !== 1'b1 || push !== 1'b0) begin n_fail++; $display("FAIL ret_strobes got push=%b pop=%b exp 0 1", push, pop); end
        tick();
        n_cmp++; if (pc !== 12'h021 || depth !== 4'd0) begin n_fail++; $display("FAIL ret_next got pc=%h depth=%0d exp 021 0", pc, depth); end
        idle_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        goto_pc(12'h050);
        call = 1'b1; jump = 1'b1; branch_taken = 1'b1; target = 12'h200;
        #1;
        n_cmp++; if (push !== 1'b1 || pop !== 1'b0) begin n_fail++; $display("FAIL prio_call_strobes got push=%b pop=%b exp 1 0", push, pop); end
        tick();
        n_cmp++; if (pc !== 12'h200 || depth !== 4'd1) begin n_fail++; $display("FAIL prio_call_next got pc=%h depth=%0d exp 200 1", pc, depth); end
        idle_inputs();
        halt = 1'b1; ret = 1'b1; stack_top = 12'h777;
        #1;
        n_cmp++; if (pop !== 1'b0) begin n_fail++; $display("FAIL halt_ret_pop got %b exp 0", pop); end
        tick();
        n_cmp++; if (halted !== 1'b1 || pc !== 12'h200) begin n_fail++; $display("FAIL halt_enter got h=%b pc=%h exp 1 200", halted, pc); end
        idle_inputs();
        call = 1'b1; target = 12'h333;
        #1;
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL halt_push got %b exp 0", push); end
        tick();
        n_cmp++; if (pc !== 12'h200 || depth !== 4'd1 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_frozen got pc=%h depth=%0d h=%b exp 200 1 1", pc, depth, halted); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        goto_pc(12'hFFF);
        n_cmp++; if (push_data !== 12'h000) begin n_fail++; $display("FAIL wrap_push_data got %h exp 000", push_data); end
        tick();
        n_cmp++; if (pc !== 12'h000) begin n_fail++; $display("FAIL wrap_seq got %h exp 000", pc); end
        goto_pc(12'hFFF);
        call = 1'b1; target = 12'h123;
        #1;
        n_cmp++; if (push !== 1'b1 || push_data !== 12'h000) begin n_fail++; $display("FAIL wrap_call got push=%b data=%h exp 1 000", push, push_data); end
        tick();
        n_cmp++; if (pc !== 12'h123) begin n_fail++; $display("FAIL wrap_call_pc got %h exp 123", pc); end
        idle_inputs();
    endtask

    task automatic test_stack_bounds();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            call = 1'b1; target = 12'(12'h300 + i);
            tick();
        end
        idle_inputs();
        n_cmp++; if (depth !== 4'd8 || pc !== 12'h307) begin n_fail++; $display("FAIL fill_stack got depth=%0d pc=%h exp 8 307", depth, pc); end
        call = 1'b1; target = 12'h3F0;
        #1;
`ifdef STACK_GUARD_EN
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL full_call_push got %b exp 0", push); end
        tick();
        n_cmp++; if (fault !== 1'b1 || pc !== 12'h307 || depth !== 4'd8) begin n_fail++; $display("FAIL full_call_fault got f=%b pc=%h depth=%0d exp 1 307 8", fault, pc, depth); end
`else
        n_cmp++; if (push !== 1'b1) begin n_fail++; $display("FAIL full_call_push got %b exp 1", push); end
        tick();
        n_cmp++; if (fault !== 1'b0 || pc !== 12'h3F0 || depth !== 4'd8) begin n_fail++; $display("FAIL full_call_sat got f=%b pc=%h depth=%0d exp 0 3f0 8", fault, pc, depth); end
`endif
        do_reset();
        ret = 1'b1; stack_top = 12'h0AB;
        #1;
`ifdef STACK_GUARD_EN
        n_cmp++; if (pop !== 1'b0) begin n_fail++; $display("FAIL empty_ret_pop got %b exp 0", pop); end
        tick();
        n_cmp++; if (fault !== 1'b1 || pc !== 12'h010 || depth !== 4'd0) begin n_fail++; $display("FAIL empty_ret_fault got f=%b pc=%h depth=%0d exp 1 010 0", fault, pc, depth); end
`else
        n_cmp++; if (pop !== 1'b1) begin n_fail++; $display("FAIL empty_ret_pop got %b exp 1", pop); end
        tick();
        n_cmp++; if (fault !== 1'b0 || pc !== 12'h0AB || depth !== 4'd0) begin n_fail++; $display("FAIL empty_ret_sat got f=%b pc=%h depth=%0d exp 0 0ab 0", fault, pc, depth); end
`endif
        idle_inputs();
    endtask

    task automatic test_stall_and_reset();
        do_reset();
        stall = 1'b1; call = 1'b1; target = 12'h400;
        #1;
        n_cmp++; if (push !== 1'b0) begin n_fail++; $display("FAIL stall_push got %b exp 0", push); end
        tick();
        n_cmp++; if (pc !== 12'h010 || depth !== 4'd0) begin n_fail++; $display("FAIL stall_hold got pc=%h depth=%0d exp 010 0", pc, depth); end
        stall = 1'b0;
        tick();
        n_cmp++; if (pc !== 12'h400 || depth !== 4'd1) begin n_fail++; $display("FAIL post_stall_call got pc=%h depth=%0d exp 400 1", pc, depth); end
        idle_inputs();
        ret = 1'b1; rst = 1'b1; stack_top = 12'h555;
        #1;
        n_cmp++; if (pop !== 1'b0 || push !== 1'b0) begin n_fail++; $display("FAIL rst_ret_strobes got push=%b pop=%b exp 0 0", push, pop); end
        tick();
        n_cmp++; if (pc !== 12'h010 || depth !== 4'd0) begin n_fail++; $display("FAIL rst_ret_next got pc=%h depth=%0d exp 010 0", pc, depth); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_call_ret();
        test_priority();
        test_wrap();
        test_stack_bounds();
        test_stall_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
